pipe_stage_skid: RTL



---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_entry.sv | 67 ++++++
 rtl/pipe_stage_skid.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared types and helpers for the skid-buffered pipeline stage.
//            Holds the stage state encoding, the default thread-tag width
//            and a saturating counter add.
// Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

   // Stage occupancy state; the encoding doubles as the occupancy count
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_e;

   localparam int DEF_THREAD_W = 2;

   // Add inc to cur and clamp the result at max_val
   function automatic logic [31:0] sat_add(input logic [31:0] cur,
                                           input logic [31:0] inc,
                                           input logic [31:0] max_val);
      logic [32:0] sum;
      sum = {1'b0, cur} + {1'b0, inc};
      if (sum > {1'b0, max_val}) begin
         return max_val;
      end
      return sum[31:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_entry.sv
`default_nettype none
// ============================================================================
// Module   : pipe_entry
// Purpose  : One storage slot of the stage: valid bit, payload and thread
//            tag. Load captures a new beat and sets valid; clear drops
//            valid but leaves the payload untouched. match flags a valid
//            entry whose tag equals match_thread.
// Revision : 1.0  initial release
// ============================================================================
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int                DATA_W   = 64,
   parameter int                THREAD_W = DEF_THREAD_W,
   parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic                clear,
   input  logic [DATA_W-1:0]   ld_data,
   input  logic [THREAD_W-1:0] ld_thread,
   input  logic [THREAD_W-1:0] match_thread,
   output logic                valid,
   output logic [DATA_W-1:0]   data,
   output logic [THREAD_W-1:0] thread,
   output logic                match
);

   logic                valid_q,  valid_d;
   logic [DATA_W-1:0]   data_q,   data_d;
   logic [THREAD_W-1:0] thread_q, thread_d;

   // Next-state: load wins over clear; payload only moves on load
   always_comb begin
      valid_d  = valid_q;
      data_d   = data_q;
      thread_d = thread_q;
      if (load) begin
         valid_d  = 1'b1;
         data_d   = ld_data;
         thread_d = ld_thread;
      end else if (clear) begin
         valid_d  = 1'b0;
      end
   end

   // Slot registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q  <= 1'b0;
         data_q   <= RST_VAL;
         thread_q <= '0;
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         thread_q <= thread_d;
      end
   end

   assign valid  = valid_q;
   assign data   = data_q;
   assign thread = thread_q;
   assign match  = valid_q & (thread_q == match_thread);

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Generic valid/ready pipeline stage register with a 2-entry
//            skid buffer (head + skid) so in_ready is a flop. Supports a
//            global flush and a thread-selective squash.
//            Optional macro PIPE_STAGE_PERF_EN adds stall_cnt / kill_cnt.
// Revision : 1.0  initial release
// ============================================================================
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                DATA_W   = 64,
   parameter int                THREAD_W = DEF_THREAD_W,
   parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [THREAD_W-1:0] in_thread,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic [THREAD_W-1:0] out_thread,
   input  logic                flush,
   input  logic                squash_en,
   input  logic [THREAD_W-1:0] squash_thread,
   output logic [1:0]          occupancy
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]         stall_cnt,
   output logic [15:0]         kill_cnt
`endif
);

   logic                head_valid, skid_valid;
   logic [DATA_W-1:0]   head_data,  skid_data;
   logic [THREAD_W-1:0] head_thread, skid_thread;
   logic                head_match, skid_match;

   logic                accept, drain, squash_act, in_match;
   logic                head_rem, skid_rem;
   logic                head_keep, skid_keep, in_keep;
   logic                head_load, head_clear, skid_load, skid_clear;
   logic                head_next, skid_next;
   logic [DATA_W-1:0]   head_ld_data;
   logic [THREAD_W-1:0] head_ld_thread;

   logic                in_ready_q, in_ready_d;
   stage_state_e        state_q, state_d;

   // Work out which beats survive this edge and where each one lands.
   // Survivors in order: held head, held skid, incoming beat (at most two).
   always_comb begin
      accept     = in_valid & in_ready_q;
      drain      = head_valid & out_ready;
      squash_act = squash_en & ~flush;
      in_match   = (in_thread == squash_thread);

      // Entries still held after the drain completes
      head_rem   = head_valid & ~drain;
      skid_rem   = skid_valid;

      // Flush kills everything; squash kills tag matches among the remainder
      head_keep  = head_rem & ~flush & ~(squash_act & head_match);
      skid_keep  = skid_rem & ~flush & ~(squash_act & skid_match);
      in_keep    = accept   & ~flush & ~(squash_act & in_match);

      // Head: hold if its beat survives, else take the oldest other survivor
      head_load      = ~head_keep & (skid_keep | in_keep);
      head_clear     = ~head_keep & ~skid_keep & ~in_keep;
      head_ld_data   = skid_keep ? skid_data   : in_data;
      head_ld_thread = skid_keep ? skid_thread : in_thread;

      // Skid: hold if both held beats survive, take the incoming beat when
      // exactly one held beat survives, otherwise empty
      skid_load  = (head_keep ^ skid_keep) & in_keep;
      skid_clear = ~(head_keep & skid_keep) & ~skid_load;

      head_next  = head_keep | skid_keep | in_keep;
      skid_next  = (head_keep & skid_keep) | skid_load;

      if (head_next && skid_next) begin
         state_d = ST_TWO;
      end else if (head_next) begin
         state_d = ST_ONE;
      end else begin
         state_d = ST_EMPTY;
      end
      in_ready_d = (state_d != ST_TWO);
   end

   // Stage state and registered upstream ready
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end

   pipe_entry #(
      .DATA_W   (DATA_W),
      .THREAD_W (THREAD_W),
      .RST_VAL  (RST_VAL)
   ) u_head (
      .clk          (clk),
      .reset        (reset),
      .load         (head_load),
      .clear        (head_clear),
      .ld_data      (head_ld_data),
      .ld_thread    (head_ld_thread),
      .match_thread (squash_thread),
      .valid        (head_valid),
      .data         (head_data),
      .thread       (head_thread),
      .match        (head_match)
   );

   pipe_entry #(
      .DATA_W   (DATA_W),
      .THREAD_W (THREAD_W),
      .RST_VAL  (RST_VAL)
   ) u_skid (
      .clk          (clk),
      .reset        (reset),
      .load         (skid_load),
      .clear        (skid_clear),
      .ld_data      (in_data),
      .ld_thread    (in_thread),
      .match_thread (squash_thread),
      .valid        (skid_valid),
      .data         (skid_data),
      .thread       (skid_thread),
      .match        (skid_match)
   );

   assign in_ready   = in_ready_q;
   assign out_valid  = head_valid;
   assign out_data   = head_data;
   assign out_thread = head_thread;
   assign occupancy  = state_q;

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] kill_cnt_q,  kill_cnt_d;
   logic [1:0]  kill_inc;
   logic        stall_hit;

   // Count stalled cycles and beats destroyed by flush or squash
   always_comb begin
      stall_hit   = head_valid & ~out_ready;
      kill_inc    = {1'b0, head_rem & ~head_keep}
                  + {1'b0, skid_rem & ~skid_keep}
                  + {1'b0, accept   & ~in_keep};
      stall_cnt_d = sat_add(stall_cnt_q, {31'd0, stall_hit}, 32'hFFFF_FFFF);
      kill_cnt_d  = 16'(sat_add({16'd0, kill_cnt_q}, {30'd0, kill_inc},
                                32'h0000_FFFF));
   end

   // Saturating performance counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         kill_cnt_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         kill_cnt_q  <= kill_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign kill_cnt  = kill_cnt_q;
`endif

endmodule
`default_nettype wire
